// File: rtl/sevenseg_scan_decoder.sv
// Rebuilds the {L,C,R,O} status word from an active-low multiplexed anode/segment bus and flags
// bad glyphs, bad scan order and stalled scanning. Define SEG_SYNC_EN for 2-flop input synchronizers.
module sevenseg_scan_decoder #(
    parameter int SETTLE  = 1,
    parameter int CONFIRM = 2,
    parameter int TIMEOUT = 64
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_an_in,
    input  logic [6:0] i_seg_in,
    output logic [3:0] o_status,
    output logic       o_status_valid,
    output logic       o_locked,
    output logic       o_glyph_err,
    output logic       o_seq_err,
    output logic       o_stall
);
    localparam int            IW        = 10;
    localparam logic [3:0]    SETTLE_C  = 4'(SETTLE);
    localparam logic [3:0]    CONFIRM_C = 4'(CONFIRM);
    localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT);
    localparam logic [6:0]    SEG_BLANK = 7'b1000000;

    typedef enum logic {HUNT, SCAN} state_t;

    logic [3:0] w_an;
    logic [6:0] w_seg;

`ifdef SEG_SYNC_EN
    logic [3:0] r_an_s1, r_an_s2;
    logic [6:0] r_seg_s1, r_seg_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_an_s1  <= '1;
            r_an_s2  <= '1;
            r_seg_s1 <= '1;
            r_seg_s2 <= '1;
        end else begin
            r_an_s1  <= i_an_in;
            r_an_s2  <= r_an_s1;
            r_seg_s1 <= i_seg_in;
            r_seg_s2 <= r_seg_s1;
        end
    end

    assign w_an  = r_an_s2;
    assign w_seg = r_seg_s2;
`else
    assign w_an  = i_an_in;
    assign w_seg = i_seg_in;
`endif

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_an_q, r_dwell, r_frame, r_prev, r_cnt, r_status;
    logic [IW-1:0] r_idle;
    logic [1:0]    r_exp;
    logic          r_need, r_status_vld, r_locked, r_glyph_err, r_seq_err, r_stall;

    logic          w_chg, w_sample, w_legal, w_glyph_ok, w_bit, w_confirmed, w_hunt, w_stall_nxt;
    logic [3:0]    w_dwell, w_dwell_nxt, w_done, w_cnt_eval;
    logic [IW-1:0] w_idle, w_idle_nxt;
    logic [1:0]    w_pos, w_exp_nxt;
    logic [6:0]    w_exp_glyph;
    logic [3:0]    w_frame_nxt, w_prev_nxt, w_cnt_nxt, w_status_nxt;
    logic          w_need_nxt, w_status_vld_nxt, w_locked_nxt, w_glyph_err_nxt, w_seq_err_nxt;

    // The change cycle itself counts as the first clock of a dwell, so both counters restart from zero there.
    assign w_chg       = (w_an != r_an_q);
    assign w_dwell     = w_chg ? 4'd0 : r_dwell;
    assign w_dwell_nxt = (w_dwell == 4'd15) ? w_dwell : w_dwell + 4'd1;
    assign w_idle      = w_chg ? '0 : r_idle;
    assign w_idle_nxt  = (w_idle >= TIMEOUT_C) ? TIMEOUT_C : w_idle + IW'(1);
    assign w_stall_nxt = (w_idle_nxt == TIMEOUT_C);
    assign w_sample    = (w_dwell == SETTLE_C);

    always_comb begin
        w_legal     = 1'b1;
        w_pos       = 2'd0;
        w_exp_glyph = 7'b0100011;
        case (w_an)
            4'b1110: begin w_pos = 2'd0; w_exp_glyph = 7'b0100011; end
            4'b1101: begin w_pos = 2'd1; w_exp_glyph = 7'b0101111; end
            4'b1011: begin w_pos = 2'd2; w_exp_glyph = 7'b1000110; end
            4'b0111: begin w_pos = 2'd3; w_exp_glyph = 7'b1000111; end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_glyph_ok  = (w_seg == SEG_BLANK) || (w_seg == w_exp_glyph);
    assign w_bit       = (w_seg != SEG_BLANK);
    assign w_done      = {w_bit, r_frame[2:0]};
    assign w_cnt_eval  = (w_done != r_prev) ? 4'd1 :
                         (r_cnt >= CONFIRM_C) ? CONFIRM_C : r_cnt + 4'd1;
    assign w_confirmed = (w_cnt_eval == CONFIRM_C);

    always_comb begin
        w_state_nxt      = r_state;
        w_exp_nxt        = r_exp;
        w_frame_nxt      = r_frame;
        w_prev_nxt       = r_prev;
        w_cnt_nxt        = r_cnt;
        w_status_nxt     = r_status;
        w_need_nxt       = r_need;
        w_status_vld_nxt = 1'b0;
        w_locked_nxt     = r_locked;
        w_glyph_err_nxt  = 1'b0;
        w_seq_err_nxt    = 1'b0;
        w_hunt           = 1'b0;

        if (w_sample) begin
            if (!w_legal) begin
                w_seq_err_nxt = 1'b1;
                w_hunt        = 1'b1;
            end else if (!w_glyph_ok) begin
                w_glyph_err_nxt = 1'b1;
                w_hunt          = 1'b1;
            end else if (r_state == HUNT) begin
                if (w_pos == 2'd0) begin
                    w_state_nxt    = SCAN;
                    w_exp_nxt      = 2'd1;
                    w_frame_nxt[0] = w_bit;
                end
            end else if (w_pos != r_exp) begin
                w_seq_err_nxt = 1'b1;
                w_hunt        = 1'b1;
            end else begin
                w_frame_nxt[w_pos] = w_bit;
                w_exp_nxt          = w_pos + 2'd1;
                if (w_pos == 2'd3) begin
                    w_cnt_nxt    = w_cnt_eval;
                    w_prev_nxt   = w_done;
                    w_locked_nxt = w_confirmed;
                    if (w_confirmed && (w_done != r_status || r_need)) begin
                        w_status_nxt     = w_done;
                        w_status_vld_nxt = 1'b1;
                        w_need_nxt       = 1'b0;
                    end
                end
            end
        end

        if (w_stall_nxt) begin
            w_hunt = 1'b1;
        end

        // Any resync forces a fresh CONFIRM run and a reload of status once it completes.
        if (w_hunt) begin
            w_state_nxt  = HUNT;
            w_cnt_nxt    = 4'd0;
            w_locked_nxt = 1'b0;
            w_need_nxt   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= HUNT;
            r_an_q       <= '1;
            r_dwell      <= '0;
            r_idle       <= '0;
            r_exp        <= '0;
            r_frame      <= '0;
            r_prev       <= '0;
            r_cnt        <= '0;
            r_status     <= '0;
            r_need       <= 1'b1;
            r_status_vld <= 1'b0;
            r_locked     <= 1'b0;
            r_glyph_err  <= 1'b0;
            r_seq_err    <= 1'b0;
            r_stall      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_an_q       <= w_an;
            r_dwell      <= w_dwell_nxt;
            r_idle       <= w_idle_nxt;
            r_exp        <= w_exp_nxt;
            r_frame      <= w_frame_nxt;
            r_prev       <= w_prev_nxt;
            r_cnt        <= w_cnt_nxt;
            r_status     <= w_status_nxt;
            r_need       <= w_need_nxt;
            r_status_vld <= w_status_vld_nxt;
            r_locked     <= w_locked_nxt;
            r_glyph_err  <= w_glyph_err_nxt;
            r_seq_err    <= w_seq_err_nxt;
            r_stall      <= w_stall_nxt;
        end
    end

    assign o_status       = r_status;
    assign o_status_valid = r_status_vld;
    assign o_locked       = r_locked;
    assign o_glyph_err    = r_glyph_err;
    assign o_seq_err      = r_seq_err;
    assign o_stall        = r_stall;

endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
- Receive-side counterpart of the four-digit L/C/R/O status display driver.
- Monitors the multiplexed anode/segment bus (active-low) and rebuilds the 4-bit status word {L,C,R,O} that drove it.
- Flags illegal glyphs, out-of-order scanning and stalled scanning.
- Used as an on-board loopback checker and by the telemetry path that reports the displayed status.

Parameters:
- SETTLE, 1: clocks after an anode change before seg_in is sampled (1..3).
- CONFIRM, 2: consecutive identical complete frames required before status updates (1..15).
- TIMEOUT, 64: clocks with no anode change before stall asserts (16..1023).

Ports:
- clk, input, 1: system clock. Same domain as the display driver unless SEG_SYNC_EN is defined.
- rst_n, input, 1: asynchronous active-low reset.
- an_in, input, 4: observed anode bus, active-low one-hot.
- seg_in, input, 7: observed segment bus, active-low, {g,f,e,d,c,b,a}.
- status, output, 4: confirmed status {L,C,R,O}.
- status_valid, output, 1: one-cycle pulse when status is loaded.
- locked, output, 1: high while CONFIRM-consistent frames keep arriving.
- glyph_err, output, 1: one-cycle pulse when an unknown glyph is sampled.
- seq_err, output, 1: one-cycle pulse on an illegal anode pattern or order.
- stall, output, 1: level, anode bus frozen for at least TIMEOUT clocks.

Behaviour:
- Reset values (async, rst_n low): status=0, status_valid=0, locked=0, glyph_err=0, seq_err=0, stall=0. FSM=HUNT, all counters 0, frame/prev registers 0.
- Legal anode codes and positions:
  - 1110 = pos0 (O)
  - 1101 = pos1 (R)
  - 1011 = pos2 (C)
  - 0111 = pos3 (L)
  - Legal order is pos0→1→2→3→0.
- Glyph table per position:
  - 1000000 (blank "0") → bit=0, at any position.
  - Expected glyph → bit=1: pos0 0100011 (o), pos1 0101111 (r), pos2 1000110 (C), pos3 1000111 (L).
  - Any other value, including another position's glyph → glyph_err pulse, frame discarded, FSM to HUNT.
- Dwell counter (4-bit, saturating at 15):
  - Cleared on any cycle where an_in differs from its registered copy an_q; otherwise increments.
  - Sampling occurs once per dwell, on the cycle where dwell==SETTLE and an_in is legal.
  - Dwells shorter than SETTLE+1 clocks are not sampled; this is treated as an order error at the next change.
- FSM:
  - HUNT: wait for the first sample at pos0 → go to SCAN with expected position 1 and frame bit0 loaded.
  - SCAN, on each sample:
    - Position equals expected → store bit.
    - Position is not expected → seq_err, go to HUNT, clear the confirm count, drop locked.
    - Pos3 stored → frame complete, evaluate (below), expected position wraps to 0, stay in SCAN.
  - An illegal an_in (not one-hot-low) sampled in any state → seq_err, go to HUNT.
- Frame evaluation on completion:
  - frame == prev: confirm count increments, saturating at CONFIRM.
  - frame != prev: confirm count = 1 and prev = frame.
  - When the count reaches CONFIRM and frame != status, or on the first confirmation after HUNT: status <= frame and status_valid pulses on the next cycle.
  - locked = 1 while confirm count == CONFIRM; locked clears on any error or HUNT entry.
- Latency, nominal driver (4-clock dwell, SETTLE=1): status updates 1 clock after the pos3 sample of the CONFIRM-th identical frame.
- Stall:
  - Idle counter increments while an_in == an_q and is cleared on any change.
  - At TIMEOUT: stall=1, locked=0, FSM to HUNT.
  - stall clears on the next anode change.
  - status holds its value throughout.
- Simultaneous events:
  - glyph_err takes priority over frame completion on the same sample.
  - stall and seq_err may assert together.
  - Reset mid-frame discards everything.
- Status changes only after CONFIRM identical frames. A single corrupted frame causes glyph_err but never changes status.

Optional Feature:
- SEG_SYNC_EN:
  - Defined: an_in and seg_in each pass through a 2-flop synchronizer (reset to all-ones = blank/off) before all logic. This adds 2 clocks to the latency and allows decoding of asynchronous board pins.
  - Undefined: inputs are used directly and must be synchronous to clk.

Test Plan:
1. Reset, then drive a nominal 4-clock scan with glyphs for status 1010 (L, R on) for 2 frames → status=1010 and one status_valid pulse after frame 2's pos3 sample; locked=1.
2. Locked on 1010, one frame with pos2 seg=0101111 (r at the C position) → glyph_err pulse, locked=0, status stays 1010; 2 clean frames of 0001 → status=0001.
3. Anode order 1110→1011 (pos1 skipped) → seq_err pulse, FSM HUNT, no status_valid.
4. an_in=1100 held for 4 clocks → seq_err pulse; normal scan resumes and status re-confirms after 2 frames.
5. Anode frozen at 1101 for 64 clocks → stall=1 at clock 64, locked=0; resume scanning → stall=0 on the first change.
6. With SEG_SYNC_EN defined, repeat test 1 → same status, status_valid 2 clocks later; rst_n asserted mid-frame → all outputs 0 asynchronously.
